// File: rtl/arm_pkg.sv
// Shared encodings for the ARM pipeline: ALU commands, DP opcodes,
// condition codes, instruction modes and status-register bit positions.
package arm_pkg;

  localparam logic [3:0] EXE_NOP = 4'b0000;
  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_MVN = 4'b1001;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam logic [1:0] MODE_DP  = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;

  localparam int SR_N = 3;
  localparam int SR_Z = 2;
  localparam int SR_C = 1;
  localparam int SR_V = 0;

  typedef struct packed {
    logic       wb_en;
    logic       mem_r_en;
    logic       mem_w_en;
    logic       b;
    logic       s;
    logic [3:0] exe_cmd;
  } ctrl_t;

endpackage

// File: rtl/register_file.sv
// Architectural register file R0..R(NUM_REGS-1): two async read ports with
// write-through bypass, one sync write port; index NUM_REGS reads the PC.
module register_file #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        rd_idx1,
  input  logic [3:0]        rd_idx2,
  input  logic [DATA_W-1:0] pc_in,
  input  logic              wr_en,
  input  logic [3:0]        wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2
);

  localparam logic [3:0] PC_IDX = 4'(NUM_REGS);

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= DATA_W'(i);
    end else if (wr_en && wr_idx != PC_IDX) begin
      regs_q[wr_idx] <= wr_data;
    end
  end

  // PC mapping takes priority so a stray write to R15 never shadows the PC.
  always_comb begin
    rd_data1 = '0;
    if (rd_idx1 == PC_IDX)                 rd_data1 = pc_in;
    else if (wr_en && wr_idx == rd_idx1)   rd_data1 = wr_data;
    else                                   rd_data1 = regs_q[rd_idx1];
  end

  always_comb begin
    rd_data2 = '0;
    if (rd_idx2 == PC_IDX)                 rd_data2 = pc_in;
    else if (wr_en && wr_idx == rd_idx2)   rd_data2 = wr_data;
    else                                   rd_data2 = regs_q[rd_idx2];
  end

endmodule

// File: rtl/id_stage.sv
// Instruction decode stage: control decode, condition evaluation, hazard/condition
// suppression and operand fetch from the register file.
module id_stage
  import arm_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [3:0]        sr_in,
  input  logic              hazard,
  input  logic              wb_wb_en,
  input  logic [3:0]        wb_dest,
  input  logic [DATA_W-1:0] wb_value,
  output logic              wb_en,
  output logic              mem_r_en,
  output logic              mem_w_en,
  output logic              b,
  output logic              s,
  output logic [3:0]        exe_cmd,
  output logic [DATA_W-1:0] value_rn,
  output logic [DATA_W-1:0] value_rm,
  output logic [11:0]       shift_operand,
  output logic              imm,
  output logic [23:0]       imm_signed_24,
  output logic [3:0]        dest,
  output logic [DATA_W-1:0] pc,
  output logic [3:0]        src1,
  output logic [3:0]        src2,
  output logic              two_src
);

  logic [3:0] cond_f;
  logic [1:0] mode_f;
  logic       i_f;
  logic [3:0] opcode_f;
  logic       s_f;
  logic [3:0] rn_f;
  logic [3:0] rd_f;
  logic [3:0] rm_f;

  assign cond_f   = instr[31:28];
  assign mode_f   = instr[27:26];
  assign i_f      = instr[25];
  assign opcode_f = instr[24:21];
  assign s_f      = instr[20];
  assign rn_f     = instr[19:16];
  assign rd_f     = instr[15:12];
  assign rm_f     = instr[3:0];

  logic sr_n, sr_z, sr_c, sr_v;
  assign sr_n = sr_in[SR_N];
  assign sr_z = sr_in[SR_Z];
  assign sr_c = sr_in[SR_C];
  assign sr_v = sr_in[SR_V];

  ctrl_t ctrl_raw;
  ctrl_t ctrl_out;
  logic  cond_ok;
  logic  kill;
  logic  is_str;

  always_comb begin
    ctrl_raw = '0;
    unique case (mode_f)
      MODE_DP: begin
        ctrl_raw.s     = s_f;
        ctrl_raw.wb_en = 1'b1;
        case (opcode_f)
          OP_MOV:  ctrl_raw.exe_cmd = EXE_MOV;
          OP_MVN:  ctrl_raw.exe_cmd = EXE_MVN;
          OP_ADD:  ctrl_raw.exe_cmd = EXE_ADD;
          OP_ADC:  ctrl_raw.exe_cmd = EXE_ADC;
          OP_SUB:  ctrl_raw.exe_cmd = EXE_SUB;
          OP_SBC:  ctrl_raw.exe_cmd = EXE_SBC;
          OP_AND:  ctrl_raw.exe_cmd = EXE_AND;
          OP_ORR:  ctrl_raw.exe_cmd = EXE_ORR;
          OP_EOR:  ctrl_raw.exe_cmd = EXE_EOR;
          OP_CMP: begin
            ctrl_raw.exe_cmd = EXE_SUB;
            ctrl_raw.wb_en   = 1'b0;
          end
          OP_TST: begin
            ctrl_raw.exe_cmd = EXE_AND;
            ctrl_raw.wb_en   = 1'b0;
          end
          default: begin
            ctrl_raw.exe_cmd = EXE_NOP;
            ctrl_raw.wb_en   = 1'b0;
          end
        endcase
      end
      MODE_MEM: begin
        ctrl_raw.exe_cmd  = EXE_ADD;
        ctrl_raw.mem_r_en = s_f;
        ctrl_raw.wb_en    = s_f;
        ctrl_raw.mem_w_en = ~s_f;
      end
      MODE_BR: begin
        ctrl_raw.b = 1'b1;
      end
      default: ctrl_raw = '0;
    endcase
  end

  always_comb begin
    cond_ok = 1'b0;
    case (cond_f)
      COND_EQ: cond_ok = sr_z;
      COND_NE: cond_ok = ~sr_z;
      COND_CS: cond_ok = sr_c;
      COND_CC: cond_ok = ~sr_c;
      COND_MI: cond_ok = sr_n;
      COND_PL: cond_ok = ~sr_n;
      COND_VS: cond_ok = sr_v;
      COND_VC: cond_ok = ~sr_v;
      COND_HI: cond_ok = sr_c & ~sr_z;
      COND_LS: cond_ok = ~sr_c | sr_z;
      COND_GE: cond_ok = (sr_n == sr_v);
      COND_LT: cond_ok = (sr_n != sr_v);
      COND_GT: cond_ok = ~sr_z & (sr_n == sr_v);
      COND_LE: cond_ok = sr_z | (sr_n != sr_v);
      COND_AL: cond_ok = 1'b1;
      COND_NV: cond_ok = 1'b0;
      default: cond_ok = 1'b0;
    endcase
  end

  assign kill     = hazard | ~cond_ok;
  assign ctrl_out = kill ? ctrl_t'('0) : ctrl_raw;

  assign wb_en    = ctrl_out.wb_en;
  assign mem_r_en = ctrl_out.mem_r_en;
  assign mem_w_en = ctrl_out.mem_w_en;
  assign b        = ctrl_out.b;
  assign s        = ctrl_out.s;
  assign exe_cmd  = ctrl_out.exe_cmd;

  // A store reads Rd as its data operand, so it is the second live source.
  assign is_str  = (mode_f == MODE_MEM) && !s_f;
  assign src1    = rn_f;
  assign src2    = is_str ? rd_f : rm_f;
  assign two_src = ~i_f | is_str;

  assign shift_operand = instr[11:0];
  assign imm           = i_f;
  assign imm_signed_24 = instr[23:0];
  assign dest          = rd_f;
  assign pc            = pc_in;

  register_file #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_register_file (
    .clk      (clk),
    .rst      (rst),
    .rd_idx1  (rn_f),
    .rd_idx2  (src2),
    .pc_in    (pc_in),
    .wr_en    (wb_wb_en),
    .wr_idx   (wb_dest),
    .wr_data  (wb_value),
    .rd_data1 (value_rn),
    .rd_data2 (value_rm)
  );

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: behavioural model checked every negedge, plus directed
// literal checks on known instructions and randomized traffic with resets.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr, pc_in, wb_value;
  logic [3:0]  sr_in, wb_dest;
  logic        hazard, wb_wb_en;

  logic        wb_en, mem_r_en, mem_w_en, b, s, imm, two_src;
  logic [3:0]  exe_cmd, dest, src1, src2;
  logic [31:0] value_rn, value_rm, pc;
  logic [11:0] shift_operand;
  logic [23:0] imm_signed_24;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  id_stage dut (
    .clk(clk), .rst(rst), .instr(instr), .pc_in(pc_in), .sr_in(sr_in),
    .hazard(hazard), .wb_wb_en(wb_wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
    .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .b(b), .s(s),
    .exe_cmd(exe_cmd), .value_rn(value_rn), .value_rm(value_rm),
    .shift_operand(shift_operand), .imm(imm), .imm_signed_24(imm_signed_24),
    .dest(dest), .pc(pc), .src1(src1), .src2(src2), .two_src(two_src)
  );

  always #5 clk = ~clk;

  // Reference register contents and ALU command table (-1 = undefined opcode).
  logic [31:0] m_regs [15];
  int          dp_cmd [16];

  initial begin
    dp_cmd = '{6, 8, 4, -1, 2, 3, 5, -1, 6, -1, 4, -1, 7, 1, -1, 9};
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 15; i++) m_regs[i] = i;
    end else if (wb_wb_en && wb_dest != 4'd15) begin
      m_regs[wb_dest] = wb_value;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t instr=%h sr=%b hz=%b)",
               name, act, exp, $time, instr, sr_in, hazard);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [3:0] idx);
    if (idx == 4'd15) return pc_in;
    if (wb_wb_en && wb_dest == idx) return wb_value;
    return m_regs[idx];
  endfunction

  // ARM conditions come in pairs: cond[3:1] picks a predicate, cond[0] negates it.
  function automatic bit m_cond(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    if (c == 4'b1111) return 0;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1;
    endcase
    return c[0] ? !base : base;
  endfunction

  task automatic check_all();
    int op, md, sb, ex;
    bit e_wb, e_mr, e_mw, e_b, e_s, e_str;
    logic [3:0] e_src2;
    md = int'(instr[27:26]); op = int'(instr[24:21]); sb = int'(instr[20]);
    e_wb = 0; e_mr = 0; e_mw = 0; e_b = 0; e_s = 0; ex = 0;
    if (md == 0) begin
      e_s = sb[0];
      if (dp_cmd[op] >= 0) begin
        ex = dp_cmd[op];
        e_wb = !(op == 10 || op == 8);
      end
    end else if (md == 1) begin
      ex = 2;
      if (sb == 1) begin e_mr = 1; e_wb = 1; end
      else e_mw = 1;
    end else if (md == 2) begin
      e_b = 1;
    end
    if (hazard || !m_cond(instr[31:28], sr_in)) begin
      e_wb = 0; e_mr = 0; e_mw = 0; e_b = 0; e_s = 0; ex = 0;
    end
    e_str  = (md == 1) && (sb == 0);
    e_src2 = e_str ? instr[15:12] : instr[3:0];
    chk("wb_en", wb_en, e_wb);
    chk("mem_r_en", mem_r_en, e_mr);
    chk("mem_w_en", mem_w_en, e_mw);
    chk("b", b, e_b);
    chk("s", s, e_s);
    chk("exe_cmd", exe_cmd, ex);
    chk("src1", src1, instr[19:16]);
    chk("src2", src2, e_src2);
    chk("two_src", two_src, !instr[25] || e_str);
    chk("value_rn", value_rn, m_read(instr[19:16]));
    chk("value_rm", value_rm, m_read(e_src2));
    chk("shift_operand", shift_operand, instr[11:0]);
    chk("imm", imm, instr[25]);
    chk("imm_signed_24", imm_signed_24, instr[23:0]);
    chk("dest", dest, instr[15:12]);
    chk("pc", pc, pc_in);
  endtask

  always @(negedge clk) if (chk_en) check_all();

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; instr = '0; pc_in = 32'h0000_1000; sr_in = '0; hazard = 1'b0;
    wb_wb_en = 1'b0; wb_dest = '0; wb_value = '0;
    chk_en = 1'b1;
    step();
    #1;
    chk("rst_wb_en", wb_en, 0);
    chk("rst_exe_cmd", exe_cmd, 0);
    chk("rst_r0", value_rn, 0);
    step();
    rst = 1'b0;

    // MOV R1,#5
    instr = 32'hE3A0_1005; #1;
    chk("mov_wb_en", wb_en, 1);
    chk("mov_exe", exe_cmd, 4'b0001);
    chk("mov_imm", imm, 1);
    chk("mov_shift", shift_operand, 12'h005);
    chk("mov_dest", dest, 1);
    chk("mov_two_src", two_src, 0);
    step();

    // ADD R2,R3,R4
    instr = 32'hE083_2004; #1;
    chk("add_rn", value_rn, 3);
    chk("add_rm", value_rm, 4);
    chk("add_exe", exe_cmd, 4'b0010);
    chk("add_src1", src1, 3);
    chk("add_src2", src2, 4);
    chk("add_two_src", two_src, 1);
    step();

    wb_wb_en = 1'b1; wb_dest = 4'd3; wb_value = 32'hDEAD_BEEF; #1;
    chk("bypass_rn", value_rn, 32'hDEAD_BEEF);
    step();
    wb_wb_en = 1'b0; #1;
    chk("stored_rn", value_rn, 32'hDEAD_BEEF);
    step();

    instr = 32'h0083_2004; sr_in = 4'b0000; #1;
    chk("addeq_fail_wb", wb_en, 0);
    chk("addeq_fail_exe", exe_cmd, 0);
    step();
    sr_in = 4'b0100; #1;
    chk("addeq_pass_wb", wb_en, 1);
    step();
    hazard = 1'b1; #1;
    chk("hazard_wb", wb_en, 0);
    chk("hazard_exe", exe_cmd, 0);
    step();
    hazard = 1'b0; sr_in = 4'b0000;

    // STR R1,[R2,#4]
    instr = 32'hE582_1004; #1;
    chk("str_mem_w", mem_w_en, 1);
    chk("str_wb", wb_en, 0);
    chk("str_exe", exe_cmd, 4'b0010);
    chk("str_src2", src2, 1);
    chk("str_two_src", two_src, 1);
    chk("str_rm", value_rm, 1);
    step();

    instr = 32'hEA00_0002; #1;
    chk("b_b", b, 1);
    chk("b_imm24", imm_signed_24, 24'h000002);
    chk("b_wb", wb_en, 0);
    step();

    pc_in = 32'h0000_1234; instr = 32'hE08F_200F;
    wb_wb_en = 1'b1; wb_dest = 4'd15; wb_value = 32'h5555_AAAA; #1;
    chk("r15_rn", value_rn, 32'h0000_1234);
    chk("r15_rm", value_rm, 32'h0000_1234);
    step();

    wb_dest = 4'd5; wb_value = 32'h0000_00FF;
    step();
    wb_wb_en = 1'b0; instr = 32'hE085_2004; #1;
    chk("r5_written", value_rn, 32'hFF);
    #1 rst = 1'b1; #1;
    chk("r5_after_rst", value_rn, 5);
    step();
    rst = 1'b0;

    // Reset held across a write edge must win.
    wb_wb_en = 1'b1; wb_dest = 4'd5; wb_value = 32'h77; rst = 1'b1;
    step();
    rst = 1'b0; wb_wb_en = 1'b0; #1;
    chk("rst_over_write", value_rn, 5);
    step();

    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [3:0] c;
      c = ($urandom_range(0, 1) == 0) ? 4'hE : 4'($urandom_range(0, 15));
      instr    = {c, $urandom_range(0, 3) == 3 ? 2'b00 : 2'($urandom_range(0, 2)),
                  28'($urandom) >> 2 };
      instr[31:28] = c;
      pc_in    = $urandom;
      sr_in    = 4'($urandom_range(0, 15));
      hazard   = ($urandom_range(0, 4) == 0);
      wb_wb_en = ($urandom_range(0, 1) == 1);
      wb_dest  = 4'($urandom_range(0, 15));
      wb_value = $urandom;
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1; #1; rst = 1'b0;
      end
      step();
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
